// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO feeding a frame serialiser with
// configurable data width, parity and stop bits at a fixed CLK_FREQ/BAUD bit period.
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 full,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx_empty,
  output logic                 tx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (STOP_BITS * DIV > 1) ? $clog2(STOP_BITS * DIV) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 push, pop, load;

  // Odd mode makes data+parity have an odd ones-count, even mode an even one.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    push     = wr_en && !full;
    pop      = 1'b0;
    load     = 1'b0;
    ovf_d    = wr_en && full;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) load = 1'b1;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = BIT_LAST;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              cnt_d   = STOP_LAST;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = STOP_LAST;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is waiting.
          if (count_q != '0) load = 1'b1;
          else               state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      cnt_d   = BIT_LAST;
      tx_d    = 1'b0;
      shift_d = mem_q[rd_ptr_q];
      par_d   = parity_bit(mem_q[rd_ptr_q]);
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy and state decide what is valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign full     = (count_q == CNT_FULL);
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_empty = (count_q == '0) && (state_q == S_IDLE);
  assign tx       = tx_q;

endmodule
